// File: rtl/dpsram_fifo_ctrl.sv
// Controller that turns an external dual-port SRAM into a FIFO.
// Port A is the write port and port B is the read port. The SRAM read has a
// one-cycle latency, so read data is presented in the cycle after the read is
// accepted. Status flags are registered and change on the same edge as COUNT.
module dpsram_fifo_ctrl #(
   parameter int DATA_WIDTH  = 20,
   parameter int ADDR_WIDTH  = 10,
   parameter int AFULL_LEVEL = 1000
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  WR_EN,
   input  logic [DATA_WIDTH-1:0] WR_DATA,
   input  logic                  RD_EN,
   output logic [DATA_WIDTH-1:0] RD_DATA,
   output logic                  RD_VALID,
   output logic                  FULL,
   output logic                  EMPTY,
   output logic                  ALMOST_FULL,
   output logic [ADDR_WIDTH:0]   COUNT,
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW,
   output logic [ADDR_WIDTH-1:0] A_ADDR,
   output logic [DATA_WIDTH-1:0] A_DIN,
   output logic                  A_WEN,
   output logic [ADDR_WIDTH-1:0] B_ADDR,
   output logic [DATA_WIDTH-1:0] B_DIN,
   output logic                  B_WEN,
   input  logic [DATA_WIDTH-1:0] B_DOUT
);

   localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] AFULL = AFULL_LEVEL[ADDR_WIDTH:0];

   logic [ADDR_WIDTH-1:0] wptr_reg;
   logic [ADDR_WIDTH-1:0] rptr_reg;
   logic [ADDR_WIDTH:0]   count_reg;
   logic [ADDR_WIDTH:0]   count_next;
   logic                  full_reg;
   logic                  empty_reg;
   logic                  afull_reg;
   logic                  rd_valid_reg;
   logic                  overflow_reg;
   logic                  underflow_reg;
   logic [DATA_WIDTH-1:0] rd_hold_reg;
   logic                  wr_accept;
   logic                  rd_accept;

   // Acceptance uses only the registered flags: a same-cycle read never frees
   // room for a write, and a same-cycle write never makes data readable.
   // Gating the write with RESET keeps the SRAM untouched while in reset.
   assign wr_accept = WR_EN & ~full_reg & ~RESET;
   assign rd_accept = RD_EN & ~empty_reg;

   // SRAM port wiring is combinational so the SRAM samples on the accepting edge.
   // Full implies equal pointers with writes blocked, so ports never collide.
   assign A_ADDR = wptr_reg;
   assign A_DIN  = WR_DATA;
   assign A_WEN  = wr_accept;
   assign B_ADDR = rptr_reg;
   assign B_DIN  = '0;
   assign B_WEN  = 1'b0;

   // Occupancy after this edge; simultaneous accepted write and read cancel.
   always_comb begin
      count_next = count_reg;
      if (wr_accept && !rd_accept) begin
         count_next = count_reg + 1'b1;
      end else if (rd_accept && !wr_accept) begin
         count_next = count_reg - 1'b1;
      end
   end

   // Pointers, occupancy and status flags; flags are derived from count_next
   // so they stay consistent with COUNT on every edge.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wptr_reg      <= '0;
         rptr_reg      <= '0;
         count_reg     <= '0;
         full_reg      <= 1'b0;
         empty_reg     <= 1'b1;
         afull_reg     <= 1'b0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (wr_accept) begin
            wptr_reg <= wptr_reg + 1'b1;
         end
         if (rd_accept) begin
            rptr_reg <= rptr_reg + 1'b1;
         end
         count_reg     <= count_next;
         full_reg      <= (count_next == DEPTH);
         empty_reg     <= (count_next == '0);
         afull_reg     <= (count_next >= AFULL);
         overflow_reg  <= WR_EN & full_reg;
         underflow_reg <= RD_EN & empty_reg;
      end
   end

   // Read-valid tracks the SRAM latency; the hold register captures the word
   // shown during a valid cycle so RD_DATA stays stable afterwards.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rd_valid_reg <= 1'b0;
         rd_hold_reg  <= '0;
      end else begin
         rd_valid_reg <= rd_accept;
         if (rd_valid_reg) begin
            rd_hold_reg <= B_DOUT;
         end
      end
   end

   assign RD_DATA     = rd_valid_reg ? B_DOUT : rd_hold_reg;
   assign RD_VALID    = rd_valid_reg;
   assign FULL        = full_reg;
   assign EMPTY       = empty_reg;
   assign ALMOST_FULL = afull_reg;
   assign COUNT       = count_reg;
   assign OVERFLOW    = overflow_reg;
   assign UNDERFLOW   = underflow_reg;

endmodule
